// File: rtl/vec_unit_pkg.sv
// Shared definitions for the vector unit arithmetic blocks.
//   sub_state_e        : control states of the digit-serial subtractor
//   VEC_ELEM_W         : default element width of a vector lane
//   SUB_DIGIT_DEFAULT  : default number of bits retired per cycle by the subtractor
package vec_unit_pkg;

    typedef enum logic [1:0] {
        SUB_IDLE = 2'd0,
        SUB_BUSY = 2'd1,
        SUB_DONE = 2'd2
    } sub_state_e;

    localparam int VEC_ELEM_W        = 32;
    localparam int SUB_DIGIT_DEFAULT = 8;

endpackage : vec_unit_pkg

// File: rtl/sub_digit_slice.sv
// One digit of the serial subtractor datapath: DIGIT 1-bit full-adder cells
// chained as a ripple.
//   a    : DIGIT-bit addend slice
//   b    : DIGIT-bit addend slice (already inverted subtrahend bits)
//   cin  : carry into the least significant cell
//   s    : DIGIT-bit sum slice
//   cout : carry out of the most significant cell
module sub_digit_slice #(
    parameter int DIGIT = 8
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout
);

    logic [DIGIT:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end

    assign cout = c[DIGIT];

endmodule : sub_digit_slice

// File: rtl/vec_serial_subtractor.sv
// Digit-serial subtractor: diff = a - b computed as a + ~b + 1, DIGIT bits per
// cycle, least significant digit first. Valid/ready handshake on both sides.
//   clk_i       : clock, all state on rising edge
//   rst_i       : synchronous reset, active-high
//   in_valid_i  : operand pair valid
//   in_ready_o  : block can accept operands (IDLE only)
//   a_i, b_i    : minuend, subtrahend (captured on accept)
//   out_valid_o : result valid (DONE)
//   out_ready_i : consumer accepts result
//   diff_o      : a - b mod 2^WIDTH
//   borrow_o    : a < b unsigned
//   ovf_o       : signed overflow
//   zero_o      : diff == 0
//
// state    | meaning
// ---------+--------------------------------------------------------------
// SUB_IDLE | waiting for operands, in_ready_o high
// SUB_BUSY | one digit per cycle, N cycles, carry rippling through carry_q
// SUB_DONE | result and flags held until the consumer takes them
module vec_serial_subtractor
    import vec_unit_pkg::*;
#(
    parameter int WIDTH = VEC_ELEM_W,
    parameter int DIGIT = SUB_DIGIT_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_o,
    output logic             ovf_o,
    output logic             zero_o
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

    if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
        $error("vec_serial_subtractor: WIDTH must be a multiple of DIGIT");
    end

    sub_state_e state_q, state_d;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] nb_q;
    logic             b_msb_q;
    logic             carry_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             ovf_q;
    logic             zero_q;

    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] nb_dig;
    logic [DIGIT-1:0] s_dig;
    logic             c_dig;
    logic [WIDTH-1:0] diff_nxt;
    logic             last_step;

    assign a_dig     = a_q[count_q*DIGIT +: DIGIT];
    assign nb_dig    = nb_q[count_q*DIGIT +: DIGIT];
    assign last_step = (count_q == LAST_STEP);

    sub_digit_slice #(
        .DIGIT (DIGIT)
    ) u_slice (
        .a    (a_dig),
        .b    (nb_dig),
        .cin  (carry_q),
        .s    (s_dig),
        .cout (c_dig)
    );

    // Result with the current digit merged in; on the last step this is the
    // complete difference, so flags can be registered from it directly.
    always_comb begin
        diff_nxt = diff_q;
        diff_nxt[count_q*DIGIT +: DIGIT] = s_dig;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= SUB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SUB_IDLE: if (in_valid_i)  state_d = SUB_BUSY;
            SUB_BUSY: if (last_step)   state_d = SUB_DONE;
            SUB_DONE: if (out_ready_i) state_d = SUB_IDLE;
            default:                   state_d = SUB_IDLE;
        endcase
    end

    always_comb begin
        in_ready_o  = (state_q == SUB_IDLE);
        out_valid_o = (state_q == SUB_DONE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_q      <= '0;
            nb_q     <= '0;
            b_msb_q  <= 1'b0;
            carry_q  <= 1'b1;
            count_q  <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            unique case (state_q)
                SUB_IDLE: begin
                    if (in_valid_i) begin
                        a_q     <= a_i;
                        nb_q    <= ~b_i;
                        b_msb_q <= b_i[WIDTH-1];
                        carry_q <= 1'b1;
                        count_q <= '0;
                    end
                end
                SUB_BUSY: begin
                    diff_q  <= diff_nxt;
                    carry_q <= c_dig;
                    count_q <= count_q + CW'(1);
                    if (last_step) begin
                        // Final carry of a + ~b + 1 is the inverse of the borrow.
                        borrow_q <= ~c_dig;
                        zero_q   <= (diff_nxt == '0);
                        ovf_q    <= (a_q[WIDTH-1] != b_msb_q) &&
                                    (diff_nxt[WIDTH-1] != a_q[WIDTH-1]);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign diff_o   = diff_q;
    assign borrow_o = borrow_q;
    assign ovf_o    = ovf_q;
    assign zero_o   = zero_q;

endmodule : vec_serial_subtractor

// File: tb/tb_vec_serial_subtractor.sv
module tb_vec_serial_subtractor;

    localparam int WIDTH = 32;
    localparam int DIGIT = 8;
    localparam int LAT   = WIDTH / DIGIT + 1;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [WIDTH-1:0]  a_i;
    logic [WIDTH-1:0]  b_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [WIDTH-1:0]  diff_o;
    logic              borrow_o;
    logic              ovf_o;
    logic              zero_o;

    int tests = 0;
    int fails = 0;

    vec_serial_subtractor #(
        .WIDTH (WIDTH),
        .DIGIT (DIGIT)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .a_i         (a_i),
        .b_i         (b_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .diff_o      (diff_o),
        .borrow_o    (borrow_o),
        .ovf_o       (ovf_o),
        .zero_o      (zero_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Issue one operation from IDLE, wait for out_valid_o (bounded), capture
    // the result, then complete the output handshake.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          output logic [WIDTH-1:0] d, output logic [2:0] flg,
                          output int lat, output logic acc);
        acc        = in_ready_o;
        in_valid_i = 1'b1;
        a_i        = a;
        b_i        = b;
        lat        = 0;
        do begin
            step();
            in_valid_i = 1'b0;
            a_i        = $urandom;
            b_i        = $urandom;
            lat++;
        end while (!out_valid_o && lat < 50);
        d           = diff_o;
        flg         = {borrow_o, ovf_o, zero_o};
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i       = 1'b1;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        a_i         = '0;
        b_i         = '0;
        repeat (3) step();
        rst_i = 1'b0;
        tests++;
        if ({in_ready_o, out_valid_o} !== 2'b10) begin
            fails++;
            $display("FAIL reset_handshake: got rdy/vld %b expected 10", {in_ready_o, out_valid_o});
        end
        tests++;
        if ({diff_o, borrow_o, ovf_o, zero_o} !== {WIDTH'(0), 3'b000}) begin
            fails++;
            $display("FAIL reset_outputs: got diff %h flags %b expected 0 000", diff_o, {borrow_o, ovf_o, zero_o});
        end
    endtask

    task automatic test_directed();
        logic [WIDTH-1:0] va [7];
        logic [WIDTH-1:0] vb [7];
        logic [WIDTH-1:0] vd [7];
        logic [2:0]       vf [7];   // {borrow, ovf, zero}
        logic [WIDTH-1:0] d;
        logic [2:0]       f;
        int               lat;
        logic             acc;
        va[0] = 32'd5;         vb[0] = 32'd3;         vd[0] = 32'd2;         vf[0] = 3'b000;
        va[1] = 32'd3;         vb[1] = 32'd5;         vd[1] = 32'hFFFFFFFE;  vf[1] = 3'b100;
        va[2] = 32'h1234ABCD;  vb[2] = 32'h1234ABCD;  vd[2] = 32'h0;         vf[2] = 3'b001;
        va[3] = 32'h80000000;  vb[3] = 32'd1;         vd[3] = 32'h7FFFFFFF;  vf[3] = 3'b010;
        va[4] = 32'h7FFFFFFF;  vb[4] = 32'hFFFFFFFF;  vd[4] = 32'h80000000;  vf[4] = 3'b110;
        va[5] = 32'h0;         vb[5] = 32'd1;         vd[5] = 32'hFFFFFFFF;  vf[5] = 3'b100;
        va[6] = 32'h00FF00FF;  vb[6] = 32'h0000FFFF;  vd[6] = 32'h00FE0100;  vf[6] = 3'b000;
        for (int i = 0; i < 7; i++) begin
            run_op(va[i], vb[i], d, f, lat, acc);
            tests++;
            if (acc !== 1'b1) begin
                fails++;
                $display("FAIL directed_accept[%0d]: got in_ready %b expected 1", i, acc);
            end
            tests++;
            if (lat != LAT) begin
                fails++;
                $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, LAT);
            end
            tests++;
            if (d !== vd[i]) begin
                fails++;
                $display("FAIL directed_diff[%0d]: got %h expected %h", i, d, vd[i]);
            end
            tests++;
            if (f !== vf[i]) begin
                fails++;
                $display("FAIL directed_flags[%0d]: got %b expected %b", i, f, vf[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        in_valid_i = 1'b1;
        a_i        = 32'd1000;
        b_i        = 32'd7;
        lat        = 0;
        do begin
            step();
            in_valid_i = 1'b0;
            lat++;
        end while (!out_valid_o && lat < 50);
        tests++;
        if (lat != LAT) begin
            fails++;
            $display("FAIL bp_latency: got %0d expected %0d", lat, LAT);
        end
        for (int i = 0; i < 10; i++) begin
            in_valid_i = i[0];
            a_i        = 32'd55 + i;
            b_i        = 32'd2;
            step();
            tests++;
            if ({out_valid_o, in_ready_o, diff_o, borrow_o, ovf_o, zero_o} !== {2'b10, 32'd993, 3'b000}) begin
                fails++;
                $display("FAIL bp_hold[%0d]: got vld/rdy %b%b diff %h flags %b expected 10 000003e1 000",
                         i, out_valid_o, in_ready_o, diff_o, {borrow_o, ovf_o, zero_o});
            end
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
        tests++;
        if ({out_valid_o, in_ready_o} !== 2'b01) begin
            fails++;
            $display("FAIL bp_release: got vld/rdy %b%b expected 01", out_valid_o, in_ready_o);
        end
        repeat (LAT + 1) step();
        tests++;
        if ({out_valid_o, in_ready_o} !== 2'b01) begin
            fails++;
            $display("FAIL bp_no_second_op: got vld/rdy %b%b expected 01", out_valid_o, in_ready_o);
        end
    endtask

    task automatic test_reset_mid_busy();
        logic [WIDTH-1:0] d;
        logic [2:0]       f;
        int               lat;
        logic             acc;
        in_valid_i = 1'b1;
        a_i        = 32'hDEADBEEF;
        b_i        = 32'h12345678;
        step();
        in_valid_i = 1'b0;
        step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        tests++;
        if ({out_valid_o, in_ready_o, diff_o} !== {2'b01, WIDTH'(0)}) begin
            fails++;
            $display("FAIL rst_busy_state: got vld/rdy %b%b diff %h expected 01 00000000", out_valid_o, in_ready_o, diff_o);
        end
        lat = 0;
        for (int i = 0; i < LAT + 2; i++) begin
            step();
            if (out_valid_o) lat++;
        end
        tests++;
        if (lat != 0) begin
            fails++;
            $display("FAIL rst_busy_spurious: got %0d valid cycles expected 0", lat);
        end
        run_op(32'd100, 32'd1, d, f, lat, acc);
        tests++;
        if ({d, f} !== {32'd99, 3'b000} || lat != LAT) begin
            fails++;
            $display("FAIL rst_busy_next_op: got diff %h flags %b lat %0d expected 00000063 000 %0d", d, f, lat, LAT);
        end
    endtask

    task automatic test_reset_mid_done();
        int lat;
        in_valid_i = 1'b1;
        a_i        = 32'd9;
        b_i        = 32'd4;
        lat        = 0;
        do begin
            step();
            in_valid_i = 1'b0;
            lat++;
        end while (!out_valid_o && lat < 50);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        tests++;
        if ({out_valid_o, in_ready_o, diff_o, borrow_o, ovf_o, zero_o} !== {2'b01, WIDTH'(0), 3'b000}) begin
            fails++;
            $display("FAIL rst_done_state: got vld/rdy %b%b diff %h flags %b expected 01 00000000 000",
                     out_valid_o, in_ready_o, diff_o, {borrow_o, ovf_o, zero_o});
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] d;
        logic [2:0]       f;
        int               lat;
        logic             acc;
        run_op(32'h00000010, 32'h00000020, d, f, lat, acc);
        tests++;
        if ({acc, d, f} !== {1'b1, 32'hFFFFFFF0, 3'b100}) begin
            fails++;
            $display("FAIL b2b_first: got acc %b diff %h flags %b expected 1 fffffff0 100", acc, d, f);
        end
        run_op(32'h80000000, 32'h80000000, d, f, lat, acc);
        tests++;
        if ({acc, d, f, lat} !== {1'b1, 32'h0, 3'b001, LAT}) begin
            fails++;
            $display("FAIL b2b_second: got acc %b diff %h flags %b lat %0d expected 1 00000000 001 %0d", acc, d, f, lat, LAT);
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] a, b, d, ed;
        logic [2:0]       f, ef;
        int               lat;
        logic             acc;
        int               bad = 0;
        for (int i = 0; i < 10000; i++) begin
            a = $urandom;
            b = (i % 16 == 0) ? a : $urandom;
            ed = a - b;
            ef = {a < b, (a[WIDTH-1] != b[WIDTH-1]) && (ed[WIDTH-1] != a[WIDTH-1]), ed == '0};
            run_op(a, b, d, f, lat, acc);
            tests++;
            if (d !== ed || f !== ef || lat != LAT || acc !== 1'b1) begin
                fails++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random[%0d]: a %h b %h got diff %h flags %b lat %0d expected %h %b %0d",
                             i, a, b, d, f, lat, ed, ef, LAT);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_busy();
        test_reset_mid_done();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_vec_serial_subtractor
